// File: rtl/spmul_pkg.sv
// Shared constants and state encoding for the SPMUL sharing arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package spmul_pkg;

  localparam int SIG_W         = 16;
  localparam int COEF_W        = 10;
  localparam int RES_W         = 16;
  localparam int SPMUL_LATENCY = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/spmul_arbiter_if.sv
// Requester-side and multiplier-side signals of the SPMUL arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/operands until ack; the multiplier is start/done.
interface spmul_arbiter_if #(
  parameter int NREQ = 4
);
  import spmul_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ*SIG_W-1:0]  req_sig;
  logic [NREQ*COEF_W-1:0] req_coef;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        res_valid;
  logic [RES_W-1:0]       res_data;
  logic                   busy;
  logic                   err_timeout;
  logic [SIG_W-1:0]       mul_sig;
  logic [COEF_W-1:0]      mul_coef;
  logic                   mul_start;
  logic                   mul_done;
  logic [RES_W-1:0]       mul_result;

  // Arbiter side: drives grants, results and the multiplier operands.
  modport master (
    input  req, req_sig, req_coef, mul_done, mul_result,
    output ack, res_valid, res_data, busy, err_timeout,
           mul_sig, mul_coef, mul_start
  );

  // Environment side: requesters plus the multiplier.
  modport slave (
    output req, req_sig, req_coef, mul_done, mul_result,
    input  ack, res_valid, res_data, busy, err_timeout,
           mul_sig, mul_coef, mul_start
  );

endinterface

// File: rtl/spmul_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req bit after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; any=0 when no request is pending.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  logic [N-1:0] upper;
  logic [N-1:0] upper_req;

  // Positions strictly after ptr form the first leg of the circular search.
  always_comb begin
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = (IW'(i) > ptr);
    end
  end

  assign upper_req = req & upper;
  assign any       = |req;

  // Lowest set bit above ptr wins; if none, wrap and take the lowest set bit.
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) winner = IW'(i);
    end
    if (upper_req != '0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (upper_req[i]) winner = IW'(i);
      end
    end
  end

endmodule

// File: rtl/spmul_arbiter.sv
// Shares one 16x10 SPMUL between NREQ requesters, round-robin, with done watchdog.
// Latency: ack and mul_start one cycle after req in IDLE; res_valid one cycle after mul_done.
// Backpressure: req is sampled only in IDLE; requesters hold req/operands until ack.
module spmul_arbiter
  import spmul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input logic             clk,
  input logic             rst_an,
  spmul_arbiter_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  if (TIMEOUT <= SPMUL_LATENCY + 1) begin : g_bad_timeout
    $error("TIMEOUT must exceed the multiplier latency plus one");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [SIG_W-1:0]    op_sig_q, op_sig_d;
  logic [COEF_W-1:0]   op_coef_q, op_coef_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     res_valid_q, res_valid_d;
  logic [RES_W-1:0]    res_data_q, res_data_d;
  logic                err_q, err_d;
  logic                start_q, start_d;

  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [SIG_W-1:0]    sel_sig;
  logic [COEF_W-1:0]   sel_coef;
  logic [NREQ-1:0]     sel_oh;
  logic [NREQ-1:0]     owner_oh;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // Route the winner's operands and build one-hot views of winner and owner.
  always_comb begin
    sel_sig  = '0;
    sel_coef = '0;
    sel_oh   = '0;
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_sig   = bus.req_sig[i*SIG_W +: SIG_W];
        sel_coef  = bus.req_coef[i*COEF_W +: COEF_W];
        sel_oh[i] = 1'b1;
      end
      if (owner_q == IW'(i)) owner_oh[i] = 1'b1;
    end
  end

  // Next-state and next-output logic; pulses default low, held values default to hold.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    op_sig_d    = op_sig_q;
    op_coef_d   = op_coef_q;
    timer_d     = timer_q;
    ack_d       = '0;
    res_valid_d = '0;
    res_data_d  = res_data_q;
    err_d       = 1'b0;
    start_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ptr_d     = pick_idx;
          owner_d   = pick_idx;
          op_sig_d  = sel_sig;
          op_coef_d = sel_coef;
          ack_d     = sel_oh;
          start_d   = 1'b1;
          timer_d   = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Timer counts cycles since ISSUE so expiry lands TIMEOUT cycles after it.
        timer_d = timer_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (bus.mul_done) begin
          res_data_d  = bus.mul_result;
          res_valid_d = owner_oh;
          state_d     = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_data_d  = '0;
          res_valid_d = owner_oh;
          err_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      owner_q     <= '0;
      op_sig_q    <= '0;
      op_coef_q   <= '0;
      timer_q     <= '0;
      ack_q       <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      op_sig_q    <= op_sig_d;
      op_coef_q   <= op_coef_d;
      timer_q     <= timer_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
      start_q     <= start_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_timeout = err_q;
  assign bus.mul_sig     = op_sig_q;
  assign bus.mul_coef    = op_coef_q;
  assign bus.mul_start   = start_q;

endmodule
